mem_read_arbiter: RTL

//  Shares the single synchronous read port of the 4-bit program/data memory between two requesters.

---
 rtl/mem_read_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// -----------------------------------------------------------------------------
// mem_read_arbiter
//   Shares the single synchronous read port of the 4-bit program/data memory
//   between instruction fetch (port 0) and operand read (port 1). One read is
//   in flight at a time: the winner's address is registered onto mem_addr, the
//   memory latency is counted out, and the returned word is presented on rdata
//   together with a one-cycle ack on the winning port.
//
//   Build option: define MEM_ARB_PRIO_EN for fixed priority (port 0 wins every
//   contested arbitration). Default build uses round robin on last_gnt.
//
// Ports
//   clk        system clock, posedge only
//   reset      synchronous, active-high
//   req0/1     read request, held until the matching ack
//   addr0/1    request address, stable while req is high
//   ack0/1     one-cycle pulse, rdata valid in that cycle
//   rdata      read data (valid only in an ack cycle)
//   busy       a transaction is in flight (state != IDLE)
//   mem_addr   registered address to the memory
//   mem_rdata  data from the memory
//
// States
//   IDLE | arbitrate; winner's address loaded into mem_addr, counter loaded
//   WAIT | memory latency being counted down
//   DONE | memory word valid; captured into rdata, ack raised, back to IDLE
// -----------------------------------------------------------------------------
module mem_read_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             gnt;
  logic             last_gnt;
  logic             pick1;

  always_comb begin
    pick1 = 1'b0;
`ifdef MEM_ARB_PRIO_EN
    pick1 = ~req0 & req1;
`else
    // Contested: the port that was not served last goes next.
    if (req0 && req1) pick1 = ~last_gnt;
    else              pick1 = req1;
`endif
  end

  // The ack is raised on the edge that leaves DONE, so the ack cycle is
  // already an IDLE cycle (busy low). A requester that drops req, or moves
  // to its next address, during its ack cycle is arbitrated cleanly on the
  // edge that ends it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      mem_addr <= '0;
      rdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt      <= pick1;
            mem_addr <= pick1 ? addr1 : addr0;
            cnt      <= CNT_LOAD;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_DONE;
        end
        S_DONE: begin
          rdata    <= mem_rdata;
          ack0     <= ~gnt;
          ack1     <= gnt;
          last_gnt <= gnt;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
